jtframe_ba0_arb: RTL
====================

JTFRAME_BA0_ARB -- requirements
Module: jtframe_ba0_arb

Interface
REQ-001 SHALL have parameter SDRAMW, default 23, SDRAM word-address width.
REQ-002 SHALL have parameter REQN, default 3, number of requesters sharing bank 0; legal range 2..4.
REQ-003 SHALL have port clk_rom, input, 1, the only clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_addr, input, REQN*SDRAMW, requester addresses, requester k in slice k.
REQ-006 SHALL have ports req_rd and req_wr, input, REQN each, per-requester read and write requests, level, held until req_rdy.
REQ-007 SHALL have ports req_din (input, REQN*16) and req_din_m (input, REQN*2), per-requester write data and byte write mask.
REQ-008 SHALL have ports req_ack, req_dst, req_dok and req_rdy, output, REQN each, per-requester handshake.
REQ-009 SHALL have port req_dout, output, 16, read data shared by all requesters, qualified by req_dok or req_rdy.
REQ-010 SHALL have ports ba0_addr (output, SDRAMW), ba0_rd (output, 1), ba0_wr (output, 1), ba0_din (output, 16) and ba0_din_m (output, 2), controller side.
REQ-011 SHALL have ports ba0_ack, ba0_dst, ba0_dok and ba0_rdy (input, 1 each) and sdram_dout (input, 16), controller responses.

Function
REQ-012 SHALL run an FSM with states IDLE, GRANT, WAIT and DONE.
REQ-013 IDLE: when any req_rd|req_wr bit is set, SHALL latch the winner index, its address, data and mask, and move to GRANT on the next edge.
REQ-014 GRANT: SHALL assert ba0_rd or ba0_wr, never both, from the latched request; on ba0_ack SHALL deassert it, pulse req_ack[winner] for 1 cycle and move to WAIT.
REQ-015 WAIT: SHALL stay until ba0_rdy, then pulse req_rdy[winner] for 1 cycle and move to DONE.
REQ-016 DONE: SHALL last 1 cycle, then return to IDLE, so one requester cannot be re-granted on the cycle it sees req_rdy.
REQ-017 Latency: a request seen in IDLE at edge n SHALL drive ba0_rd/ba0_wr high from edge n+1.
REQ-018 req_dst and req_dok SHALL equal ba0_dst and ba0_dok gated to the winner only; non-winner bits SHALL be 0.
REQ-019 req_dout SHALL be sdram_dout passed straight through, combinationally.
REQ-020 If a requester asserts req_rd and req_wr together, the write SHALL win.
REQ-021 Round-robin: after requester k is served, the search SHALL start at k+1 mod REQN, so a requester waits at most REQN-1 transactions.
REQ-022 If a requester drops its request after grant, the transaction SHALL still complete and req_rdy SHALL still pulse.
REQ-023 Requests arriving outside IDLE SHALL be ignored until IDLE.
REQ-024 Latched address, data and mask SHALL stay stable from GRANT to DONE.

Reset
REQ-025 On rst_n low, asynchronously: state SHALL be IDLE; ba0_rd, ba0_wr, all req_ack and all req_rdy SHALL be 0; ba0_addr, ba0_din and ba0_din_m SHALL be 0; the round-robin pointer SHALL be 0.
REQ-026 If reset arrives mid-transaction, the transaction SHALL be abandoned and no req_rdy SHALL be issued.

Configuration
REQ-027 With macro JTFRAME_BA0_FIXPRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the pointer SHALL be removed.
REQ-028 Without JTFRAME_BA0_FIXPRIO_EN, arbitration SHALL be round-robin as in REQ-021.

Structure
REQ-029 The FSM state enum and the REQN limit constant SHALL live in shared package jtframe_sdram_pkg.
REQ-030 Winner selection SHALL be one sub-module, jtframe_arb_pick: combinational, request vector plus pointer in, one-hot and index out.

Verification
REQ-031 Single read: req_rd[1]=1, addr=0x12345; bench controller acks after 2 cycles and gives rdy with data 0xBEEF 5 cycles later -> ba0_addr=0x12345, one req_ack[1] pulse, req_rdy[1] with req_dout=0xBEEF, other bits 0.
REQ-032 Write with mask: req_wr[0]=1, din=0xA55A, din_m=2'b01 -> ba0_wr=1, ba0_din=0xA55A, ba0_din_m=01, ba0_rd=0 throughout.
REQ-033 Fairness: all three requesters hold requests continuously -> grant order 0,1,2,0,1,2; with JTFRAME_BA0_FIXPRIO_EN the order is 0,0,0...
REQ-034 Simultaneous rd+wr on requester 2 -> a write is issued.
REQ-035 Reset pulse while in WAIT -> all outputs 0 within the same cycle, no req_rdy, next request is served normally.
REQ-036 Requester 1 drops req_rd in WAIT -> req_rdy[1] still pulses once, then the FSM returns to IDLE via DONE.

Source files
------------

// File: rtl/jtframe_sdram_pkg.sv
// rtl/jtframe_sdram_pkg.sv - shared SDRAM arbiter types and limits
package jtframe_sdram_pkg;

    localparam int REQN_MIN = 2;
    localparam int REQN_MAX = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } ba0_state_t;

    // Width of a requester index / round-robin pointer
    function automatic int ptr_w(input int n);
        return (n > 2) ? 2 : 1;
    endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// rtl/jtframe_arb_pick.sv - combinational winner pick, lowest offset from ptr_i wins
module jtframe_arb_pick
    import jtframe_sdram_pkg::*;
#(
    parameter int REQN = 3,
    parameter int PW   = 2
) (
    input  logic [REQN-1:0] req_i,
    input  logic [PW-1:0]   ptr_i,
    output logic [REQN-1:0] onehot_o,
    output logic [PW-1:0]   idx_o,
    output logic            any_o
);

    int off;
    int best_off;

    always_comb begin
        idx_o    = '0;
        off      = 0;
        best_off = REQN;
        for (int j = 0; j < REQN; j++) begin
            if (req_i[j]) begin
                off = j - int'(ptr_i);
                if (off < 0) off = off + REQN;
                if (off < best_off) begin
                    best_off = off;
                    idx_o    = PW'(j);
                end
            end
        end
        any_o    = |req_i;
        onehot_o = any_o ? (REQN'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/jtframe_ba0_arb.sv
// rtl/jtframe_ba0_arb.sv - bank 0 SDRAM arbiter; JTFRAME_BA0_FIXPRIO_EN selects fixed priority
module jtframe_ba0_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int SDRAMW = 23,
    parameter int REQN   = 3
) (
    input  logic                   clk_rom,
    input  logic                   rst_n,
    input  logic [REQN*SDRAMW-1:0] req_addr,
    input  logic [REQN-1:0]        req_rd,
    input  logic [REQN-1:0]        req_wr,
    input  logic [REQN*16-1:0]     req_din,
    input  logic [REQN*2-1:0]      req_din_m,
    output logic [REQN-1:0]        req_ack,
    output logic [REQN-1:0]        req_dst,
    output logic [REQN-1:0]        req_dok,
    output logic [REQN-1:0]        req_rdy,
    output logic [15:0]            req_dout,
    output logic [SDRAMW-1:0]      ba0_addr,
    output logic                   ba0_rd,
    output logic                   ba0_wr,
    output logic [15:0]            ba0_din,
    output logic [1:0]             ba0_din_m,
    input  logic                   ba0_ack,
    input  logic                   ba0_dst,
    input  logic                   ba0_dok,
    input  logic                   ba0_rdy,
    input  logic [15:0]            sdram_dout
);

    localparam int PW = ptr_w(REQN);

    if (REQN < REQN_MIN || REQN > REQN_MAX) begin : g_reqn_check
        $error("jtframe_ba0_arb: REQN out of range");
    end

    ba0_state_t        state_q;
    logic [REQN-1:0]   win_oh_q;
    logic [REQN-1:0]   ack_q;
    logic [REQN-1:0]   rdy_q;
    logic              rd_q;
    logic              wr_q;
    logic [SDRAMW-1:0] addr_q;
    logic [15:0]       din_q;
    logic [1:0]        dinm_q;

    logic [REQN-1:0]   pick_oh;
    logic [PW-1:0]     pick_idx;
    logic              pick_any;
    logic [PW-1:0]     ptr;

`ifdef JTFRAME_BA0_FIXPRIO_EN
    assign ptr = '0;
`else
    logic [PW-1:0] win_q;
    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    assign ptr_d = (win_q == PW'(REQN-1)) ? '0 : win_q + 1'b1;
    assign ptr   = ptr_q;
`endif

    jtframe_arb_pick #(
        .REQN (REQN),
        .PW   (PW)
    ) u_pick (
        .req_i    (req_rd | req_wr),
        .ptr_i    (ptr),
        .onehot_o (pick_oh),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_ff @(posedge clk_rom or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            win_oh_q <= '0;
            ack_q    <= '0;
            rdy_q    <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            din_q    <= '0;
            dinm_q   <= '0;
`ifdef JTFRAME_BA0_FIXPRIO_EN
`else
            win_q    <= '0;
            ptr_q    <= '0;
`endif
        end else begin
            ack_q <= '0;
            rdy_q <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (pick_any) begin
                        win_oh_q <= pick_oh;
                        addr_q   <= req_addr[pick_idx*SDRAMW +: SDRAMW];
                        din_q    <= req_din[pick_idx*16 +: 16];
                        dinm_q   <= req_din_m[pick_idx*2 +: 2];
                        // A write request masks a simultaneous read
                        wr_q     <= req_wr[pick_idx];
                        rd_q     <= ~req_wr[pick_idx];
`ifdef JTFRAME_BA0_FIXPRIO_EN
`else
                        win_q    <= pick_idx;
`endif
                        state_q  <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (ba0_ack) begin
                        rd_q    <= 1'b0;
                        wr_q    <= 1'b0;
                        ack_q   <= win_oh_q;
                        state_q <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (ba0_rdy) begin
                        rdy_q   <= win_oh_q;
`ifdef JTFRAME_BA0_FIXPRIO_EN
`else
                        ptr_q   <= ptr_d;
`endif
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign req_ack   = ack_q;
    assign req_rdy   = rdy_q;
    assign req_dst   = ba0_dst ? win_oh_q : '0;
    assign req_dok   = ba0_dok ? win_oh_q : '0;
    assign req_dout  = sdram_dout;
    assign ba0_addr  = addr_q;
    assign ba0_rd    = rd_q;
    assign ba0_wr    = wr_q;
    assign ba0_din   = din_q;
    assign ba0_din_m = dinm_q;

endmodule
